shifter_to_left_seq: RTL

Multi-cycle left shifter/rotator for the 8-bit CPU datapath. It moves one bit position per clock and reports the last bit shifted out on carry_out. It is the counterpart of the combinational right shifter and feeds the ALU result mux and the flags register. A start/busy/done handshake lets the control FSM issue variable-distance SHL and ROL instructions.

---
 rtl/shifter_to_left_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/shifter_to_left_seq.sv
// Multi-cycle left shifter/rotator: moves the operand one bit per clock and
// reports the last bit pushed out of the MSB on carry_out.
module shifter_to_left_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rotate,
    input  logic [CNT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] in_bit,
    output logic [WIDTH-1:0] out_bit,
    output logic             carry_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   count_q;
    logic               mode_q;
    logic               carry_q;

    // Handshake: start is taken only while busy=0 (IDLE); busy stays high
    // through SHIFT and DONE, and done pulses for one cycle with the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (shift_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q  <= in_bit;
                        count_q <= shift_amt;
                        mode_q  <= rotate;
                        carry_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    // In rotate mode the outgoing MSB re-enters at bit 0.
                    carry_q <= data_q[WIDTH-1];
                    data_q  <= {data_q[WIDTH-2:0], mode_q & data_q[WIDTH-1]};
                    count_q <= count_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_bit   = data_q;
    assign carry_out = carry_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
